// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, constants and fetch FSM states for the LEGv8 CPU
package cpu_pkg;

    localparam logic [10:0] OP_HALT  = 11'h7FF;
    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
    localparam logic [31:0] NOP_INST = 32'hD503201F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_HOLD   = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/cpu_branch_target.sv
// rtl/cpu_branch_target.sv - combinational branch target adder
//   pc     in  PC_W  address of the branch instruction
//   inst   in  32    branch instruction word
//   branch in  1     1: unconditional B (imm26), 0: CBZ/CBNZ (imm19)
//   target out PC_W  pc + (sign-extended offset << 2), modulo 2^PC_W
module cpu_branch_target #(
    parameter int PC_W = 64
) (
    input  logic [PC_W-1:0] pc,
    input  logic [31:0]     inst,
    input  logic            branch,
    output logic [PC_W-1:0] target
);

    logic [PC_W-1:0] offset;
    logic            unused_inst_bits;

    // Opcode bits and Rt are not part of either offset field.
    assign unused_inst_bits = ^{inst[31:26], inst[4:0]};

    always_comb begin
        offset = '0;
        if (branch) begin
            offset = {{(PC_W-26){inst[25]}}, inst[25:0]};
        end else begin
            offset = {{(PC_W-19){inst[23]}}, inst[23:5]};
        end
        target = pc + {offset[PC_W-3:0], 2'b00};
    end

endmodule

// File: rtl/cpu_fetch.sv
// rtl/cpu_fetch.sv - LEGv8 instruction fetch stage with PC, imem handshake and branch resolve
//   clk, rst_n                       clock, asynchronous active-low reset
//   imem_req/imem_addr               fetch request and address (address is always pc)
//   imem_rdata/imem_ack              instruction word and completion from memory
//   inst/inst31_21/pc/inst_valid     held instruction towards decode
//   inst_ready                       consumer retires the held instruction
//   Branch/BranchZero/BranchNonZero  branch controls of the retiring instruction
//   alu_zero                         ALU zero flag of the retiring instruction
//   halted                           a HALT has retired; fetch stopped until reset
module cpu_fetch
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ack,
    output logic [31:0]     inst,
    output logic [10:0]     inst31_21,
    output logic [PC_W-1:0] pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    input  logic            Branch,
    input  logic            BranchZero,
    input  logic            BranchNonZero,
    input  logic            alu_zero,
    output logic            halted
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;
    logic [PC_W-1:0] target;
    logic            taken;

    cpu_branch_target #(
        .PC_W (PC_W)
    ) u_branch_target (
        .pc     (pc_q),
        .inst   (inst_q),
        .branch (Branch),
        .target (target)
    );

    assign taken = Branch | (BranchZero & alu_zero) | (BranchNonZero & ~alu_zero);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (imem_ack) begin
                    inst_d  = imem_rdata;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (inst_ready) begin
                    if (inst_q[31:21] == OP_HALT) begin
                        state_d = ST_HALTED;
                    end else begin
                        pc_d    = taken ? target : pc_q + PC_W'(4);
                        state_d = ST_REQ;
                    end
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    // Handshake outputs decode state only, so reset kills imem_req at once.
    assign imem_req   = (state_q == ST_REQ);
    assign inst_valid = (state_q == ST_HOLD);
    assign halted     = (state_q == ST_HALTED);
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign inst       = inst_q;
    assign inst31_21  = inst_q[31:21];

endmodule

// File: tb/tb_cpu_fetch.sv
// tb/tb_cpu_fetch.sv - self-checking bench for cpu_fetch with a behavioural PC model
module tb_cpu_fetch;
    import cpu_pkg::*;

    localparam logic [31:0] ADD_INST  = 32'h8B020020;
    localparam logic [31:0] HALT_INST = 32'hFFE00000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] inst;
    logic [10:0] inst31_21;
    logic [63:0] pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        Branch;
    logic        BranchZero;
    logic        BranchNonZero;
    logic        alu_zero;
    logic        halted;

    logic [31:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[9:2]];

    cpu_fetch #(
        .PC_W     (64),
        .RESET_PC (64'h0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ack      (imem_ack),
        .inst          (inst),
        .inst31_21     (inst31_21),
        .pc            (pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .Branch        (Branch),
        .BranchZero    (BranchZero),
        .BranchNonZero (BranchNonZero),
        .alu_zero      (alu_zero),
        .halted        (halted)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_ack = 1'b0;
        inst_ready = 1'b0;
        Branch = 1'b0;
        BranchZero = 1'b0;
        BranchNonZero = 1'b0;
        alu_zero = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic retire(input logic b, input logic bz, input logic bnz, input logic z);
        imem_ack = 1'b0;
        Branch = b;
        BranchZero = bz;
        BranchNonZero = bnz;
        alu_zero = z;
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        Branch = 1'b0;
        BranchZero = 1'b0;
        BranchNonZero = 1'b0;
        alu_zero = 1'b0;
    endtask

    // d wait states before the ack; request and address must hold throughout.
    task automatic serve(input int d, input logic [63:0] a);
        for (int i = 0; i <= d; i++) begin
            imem_ack = (i == d);
            chk("req_held", {63'd0, imem_req}, 64'd1);
            chk("addr_held", imem_addr, a);
            chk("valid_wait", {63'd0, inst_valid}, 64'd0);
            @(negedge clk);
        end
        imem_ack = 1'b0;
        chk("valid_after_ack", {63'd0, inst_valid}, 64'd1);
    endtask

    // Straight-line execution until the instruction at target is held.
    task automatic advance_to(input logic [63:0] target);
        for (int i = 0; i < 200; i++) begin
            if (inst_valid && pc == target) break;
            if (inst_valid) begin
                retire(1'b0, 1'b0, 1'b0, 1'b0);
            end else begin
                imem_ack = imem_req;
                @(negedge clk);
                imem_ack = 1'b0;
            end
        end
        chk("advance_pc", pc, target);
        chk("advance_valid", {63'd0, inst_valid}, 64'd1);
    endtask

    function automatic logic [31:0] gen_word();
        int          imm;
        logic [31:0] w;
        imm = int'($urandom_range(0, 12)) - 6;
        case ($urandom_range(0, 4))
            0: w = NOP_INST;
            1: w = {11'h458, 21'($urandom)};
            2: w = {OP_B, 26'(imm)};
            3: w = {OP_CBZ, 19'(imm), 5'($urandom)};
            default: w = {OP_CBNZ, 19'(imm), 5'($urandom)};
        endcase
        return w;
    endfunction

    // Next PC from the architectural rule, using signed integer arithmetic.
    function automatic logic [63:0] model_next(input logic [63:0] cur, input logic [31:0] w,
                                               input logic b, input logic bz, input logic bnz,
                                               input logic z);
        longint off;
        logic   tk;
        tk = b | (bz & z) | (bnz & ~z);
        if (b) begin
            off = longint'(w[25:0]);
            if (w[25]) off = off - (longint'(1) << 26);
        end else begin
            off = longint'(w[23:5]);
            if (w[23]) off = off - (longint'(1) << 19);
        end
        return tk ? cur + 64'(off * 4) : cur + 64'd4;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] tbl_word [4];
        logic        tbl_bz   [4];
        logic        tbl_bnz  [4];
        logic        tbl_z    [4];
        logic [63:0] tbl_exp  [4];
        logic [63:0] exp_pc;
        logic [31:0] w;
        logic        rb, rbz, rbnz, rz;

        for (int i = 0; i < 256; i++) mem[i] = NOP_INST;
        mem[0] = ADD_INST;
        rst_n = 1'b0;
        imem_ack = 1'b0;
        inst_ready = 1'b0;
        Branch = 1'b0;
        BranchZero = 1'b0;
        BranchNonZero = 1'b0;
        alu_zero = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_req", {63'd0, imem_req}, 64'd0);
        chk("rst_addr", imem_addr, 64'd0);
        chk("rst_pc", pc, 64'd0);
        chk("rst_inst", {32'd0, inst}, {32'd0, NOP_INST});
        chk("rst_op", {53'd0, inst31_21}, {53'd0, 11'b11010101000});
        chk("rst_valid", {63'd0, inst_valid}, 64'd0);
        chk("rst_halted", {63'd0, halted}, 64'd0);

        // First fetch with ack tied high: REQ in cycle 2, HOLD in cycle 3.
        imem_ack = 1'b1;
        rst_n = 1'b1;
        chk("c1_req", {63'd0, imem_req}, 64'd0);
        @(negedge clk);
        chk("c2_req", {63'd0, imem_req}, 64'd1);
        chk("c2_addr", imem_addr, 64'd0);
        chk("c2_valid", {63'd0, inst_valid}, 64'd0);
        @(negedge clk);
        chk("c3_valid", {63'd0, inst_valid}, 64'd1);
        chk("c3_op", {53'd0, inst31_21}, {53'd0, 11'b10001011000});
        chk("c3_inst", {32'd0, inst}, {32'd0, ADD_INST});
        chk("c3_req", {63'd0, imem_req}, 64'd0);

        // Backpressure with stray acks, changing memory data and noisy branch inputs.
        mem[0] = 32'h12345678;
        Branch = 1'b1;
        BranchZero = 1'b1;
        alu_zero = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_inst", {32'd0, inst}, {32'd0, ADD_INST});
            chk("bp_pc", pc, 64'd0);
            chk("bp_valid", {63'd0, inst_valid}, 64'd1);
        end
        mem[0] = ADD_INST;
        retire(1'b0, 1'b0, 1'b0, 1'b0);

        // Three wait states at address 4.
        serve(3, 64'd4);
        chk("wait_pc", pc, 64'd4);

        // B imm26 = 3 at 0x10.
        mem[4] = {OP_B, 26'd3};
        advance_to(64'h10);
        chk("b_fwd_inst", {32'd0, inst}, 64'h14000003);
        retire(1'b1, 1'b0, 1'b0, 1'b0);
        chk("b_fwd_addr", imem_addr, 64'h1C);
        chk("b_fwd_req", {63'd0, imem_req}, 64'd1);

        // B imm26 = -1 at 0x10.
        do_reset();
        mem[4] = {OP_B, 26'h3FFFFFF};
        advance_to(64'h10);
        retire(1'b1, 1'b0, 1'b0, 1'b0);
        chk("b_back_addr", imem_addr, 64'h0C);
        mem[4] = NOP_INST;

        // CBZ / CBNZ imm19 = 2 at 0x20.
        tbl_word[0] = 32'hB4000040; tbl_bz[0] = 1; tbl_bnz[0] = 0; tbl_z[0] = 1; tbl_exp[0] = 64'h28;
        tbl_word[1] = 32'hB4000040; tbl_bz[1] = 1; tbl_bnz[1] = 0; tbl_z[1] = 0; tbl_exp[1] = 64'h24;
        tbl_word[2] = 32'hB5000040; tbl_bz[2] = 0; tbl_bnz[2] = 1; tbl_z[2] = 1; tbl_exp[2] = 64'h24;
        tbl_word[3] = 32'hB5000040; tbl_bz[3] = 0; tbl_bnz[3] = 1; tbl_z[3] = 0; tbl_exp[3] = 64'h28;
        for (int k = 0; k < 4; k++) begin
            do_reset();
            mem[8] = tbl_word[k];
            advance_to(64'h20);
            retire(1'b0, tbl_bz[k], tbl_bnz[k], tbl_z[k]);
            chk($sformatf("cb_case%0d", k), imem_addr, tbl_exp[k]);
        end
        mem[8] = NOP_INST;

        // Wrap: B -1 from 0 reaches the top word, then a plain instruction wraps to 0.
        do_reset();
        mem[0] = {OP_B, 26'h3FFFFFF};
        mem[255] = ADD_INST;
        advance_to(64'h0);
        retire(1'b1, 1'b0, 1'b0, 1'b0);
        chk("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("wrap_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_inst", {32'd0, inst}, {32'd0, ADD_INST});
        retire(1'b0, 1'b0, 1'b0, 1'b0);
        chk("wrap_next", imem_addr, 64'h0);
        mem[0] = ADD_INST;
        mem[255] = NOP_INST;

        // Reset asserted during a stalled request at address 4.
        do_reset();
        advance_to(64'h0);
        retire(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("mid_req_before", {63'd0, imem_req}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_req_drop", {63'd0, imem_req}, 64'd0);
        chk("mid_pc", pc, 64'd0);
        chk("mid_inst", {32'd0, inst}, {32'd0, NOP_INST});
        imem_ack = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_late_ack_inst", {32'd0, inst}, {32'd0, NOP_INST});
        chk("mid_late_ack_valid", {63'd0, inst_valid}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_restart_req", {63'd0, imem_req}, 64'd1);
        chk("mid_restart_addr", imem_addr, 64'd0);
        chk("mid_restart_valid", {63'd0, inst_valid}, 64'd0);
        imem_ack = 1'b0;

        // HALT at address 4.
        do_reset();
        mem[1] = HALT_INST;
        advance_to(64'h4);
        retire(1'b0, 1'b0, 1'b0, 1'b0);
        chk("halt_flag", {63'd0, halted}, 64'd1);
        chk("halt_req", {63'd0, imem_req}, 64'd0);
        for (int i = 0; i < 22; i++) begin
            imem_ack = 1'($urandom);
            inst_ready = 1'($urandom);
            @(negedge clk);
            chk("halt_req_stays", {63'd0, imem_req}, 64'd0);
            chk("halt_stays", {63'd0, halted}, 64'd1);
        end
        imem_ack = 1'b0;
        inst_ready = 1'b0;
        mem[1] = NOP_INST;

        // Random program, random latencies, random branch controls.
        for (int i = 0; i < 256; i++) mem[i] = gen_word();
        do_reset();
        exp_pc = 64'h0;
        @(negedge clk);
        for (int n = 0; n < 60; n++) begin
            serve(int'($urandom_range(0, 3)), exp_pc);
            w = mem[exp_pc[9:2]];
            chk("rnd_pc", pc, exp_pc);
            chk("rnd_inst", {32'd0, inst}, {32'd0, w});
            chk("rnd_op", {53'd0, inst31_21}, {53'd0, w[31:21]});
            for (int s = int'($urandom_range(0, 2)); s > 0; s--) begin
                Branch = 1'($urandom);
                BranchZero = 1'($urandom);
                BranchNonZero = 1'($urandom);
                alu_zero = 1'($urandom);
                @(negedge clk);
                chk("rnd_stall_pc", pc, exp_pc);
            end
            rb = ($urandom_range(0, 3) == 0);
            rbz = 1'($urandom);
            rbnz = 1'($urandom);
            rz = 1'($urandom);
            retire(rb, rbz, rbnz, rz);
            exp_pc = model_next(exp_pc, w, rb, rbz, rbnz, rz);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
